skin_mask_extract: RTL and testbench

- Consumes the chroma byte stream produced by the CMOS capture stage: one data strobe, one 8-bit chroma byte and a frame-valid level.
- Pairs consecutive bytes into Cb/Cr, classifies each pair as skin or non-skin by fixed threshold windows, and emits a 1-bit mask with pair coordinates.
- Accumulates a per-frame bounding box and skin-pair count for the downstream gesture classifier.
- Runs entirely in the sensor pixel-clock domain.

---
 rtl/skin_mask_extract_if.sv | 36 +++
 rtl/skin_mask_extract.sv | 164 ++++++++++++++++
 tb/tb_skin_mask_extract.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/skin_mask_extract_if.sv
// Chroma byte stream in, skin mask and per-frame box out.
// master drives the byte stream; slave is the classifier.
interface skin_mask_extract_if;
  logic        iDATA_CLK;
  logic [7:0]  iDATA;
  logic        iDATA_VALID;
  logic        oMASK_VALID;
  logic        oMASK;
  logic [9:0]  oX;
  logic [9:0]  oY;
  logic        oFRAME_DONE;
  logic        oBOX_VALID;
  logic [9:0]  oBOX_XMIN;
  logic [9:0]  oBOX_XMAX;
  logic [9:0]  oBOX_YMIN;
  logic [9:0]  oBOX_YMAX;
  logic [16:0] oSKIN_CNT;

  modport master (
    output iDATA_CLK, iDATA, iDATA_VALID,
    input  oMASK_VALID, oMASK, oX, oY,
    input  oFRAME_DONE, oBOX_VALID,
    input  oBOX_XMIN, oBOX_XMAX,
    input  oBOX_YMIN, oBOX_YMAX,
    input  oSKIN_CNT
  );

  modport slave (
    input  iDATA_CLK, iDATA, iDATA_VALID,
    output oMASK_VALID, oMASK, oX, oY,
    output oFRAME_DONE, oBOX_VALID,
    output oBOX_XMIN, oBOX_XMAX,
    output oBOX_YMIN, oBOX_YMAX,
    output oSKIN_CNT
  );
endinterface

// File: rtl/skin_mask_extract.sv
// Cb/Cr pair skin classifier with per-frame bounding box and count.
// Everything runs on the sensor pixel clock.
module skin_mask_extract #(
  parameter int H_PAIRS = 320,
  parameter int V_LINES = 480,
  parameter int CB_MIN  = 77,
  parameter int CB_MAX  = 127,
  parameter int CR_MIN  = 133,
  parameter int CR_MAX  = 173
) (
  input logic CMOS_PCLK,
  input logic iRST_N,
  skin_mask_extract_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [7:0] CB_LO = 8'(CB_MIN);
  localparam logic [7:0] CB_HI = 8'(CB_MAX);
  localparam logic [7:0] CR_LO = 8'(CR_MIN);
  localparam logic [7:0] CR_HI = 8'(CR_MAX);
  localparam logic [9:0] X_LAST = 10'(H_PAIRS - 1);
  localparam logic [9:0] Y_END  = 10'(V_LINES);
  localparam logic [9:0] MIN_INIT = 10'h3FF;
  localparam logic [16:0] CNT_SAT = 17'h1FFFF;

  logic [1:0]  state;
  logic        clk_d;
  logic        phase;
  logic [7:0]  cb;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [9:0]  w_xmin;
  logic [9:0]  w_xmax;
  logic [9:0]  w_ymin;
  logic [9:0]  w_ymax;
  logic [16:0] w_cnt;

  logic        mask_valid;
  logic        mask;
  logic [9:0]  ox;
  logic [9:0]  oy;
  logic        frame_done;
  logic        box_valid;
  logic [9:0]  xmin;
  logic [9:0]  xmax;
  logic [9:0]  ymin;
  logic [9:0]  ymax;
  logic [16:0] skin_cnt;

  logic stb;
  logic skin;
  logic in_frame;

  assign stb = bus.iDATA_CLK & ~clk_d;

  // Cr is the byte arriving now; Cb was latched on the previous strobe
  assign skin = (cb >= CB_LO) && (cb <= CB_HI) &&
                (bus.iDATA >= CR_LO) && (bus.iDATA <= CR_HI);

  assign in_frame = (y < Y_END);

  always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      clk_d      <= 1'b0;
      phase      <= 1'b0;
      cb         <= '0;
      x          <= '0;
      y          <= '0;
      w_xmin     <= MIN_INIT;
      w_xmax     <= '0;
      w_ymin     <= MIN_INIT;
      w_ymax     <= '0;
      w_cnt      <= '0;
      mask_valid <= 1'b0;
      mask       <= 1'b0;
      ox         <= '0;
      oy         <= '0;
      frame_done <= 1'b0;
      box_valid  <= 1'b0;
      xmin       <= MIN_INIT;
      xmax       <= '0;
      ymin       <= MIN_INIT;
      ymax       <= '0;
      skin_cnt   <= '0;
    end else begin
      clk_d      <= bus.iDATA_CLK;
      mask_valid <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.iDATA_VALID) begin
            state  <= ACTIVE;
            phase  <= 1'b0;
            x      <= '0;
            y      <= '0;
            w_xmin <= MIN_INIT;
            w_xmax <= '0;
            w_ymin <= MIN_INIT;
            w_ymax <= '0;
            w_cnt  <= '0;
          end
        end
        ACTIVE: begin
          if (!bus.iDATA_VALID) begin
            state <= DONE;
          end else if (stb && !phase) begin
            cb    <= bus.iDATA;
            phase <= 1'b1;
          end else if (stb) begin
            phase <= 1'b0;
            if (in_frame) begin
              mask_valid <= 1'b1;
              mask       <= skin;
              ox         <= x;
              oy         <= y;
              if (skin) begin
                if (x < w_xmin) w_xmin <= x;
                if (x > w_xmax) w_xmax <= x;
                if (y < w_ymin) w_ymin <= y;
                if (y > w_ymax) w_ymax <= y;
                if (w_cnt != CNT_SAT) w_cnt <= w_cnt + 17'd1;
              end
              if (x == X_LAST) begin
                x <= '0;
                y <= y + 10'd1;
              end else begin
                x <= x + 10'd1;
              end
            end
          end
        end
        DONE: begin
          // an empty frame's working box still holds its init values
          state      <= IDLE;
          frame_done <= 1'b1;
          box_valid  <= (w_cnt != '0);
          xmin       <= w_xmin;
          xmax       <= w_xmax;
          ymin       <= w_ymin;
          ymax       <= w_ymax;
          skin_cnt   <= w_cnt;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oMASK_VALID = mask_valid;
  assign bus.oMASK       = mask;
  assign bus.oX          = ox;
  assign bus.oY          = oy;
  assign bus.oFRAME_DONE = frame_done;
  assign bus.oBOX_VALID  = box_valid;
  assign bus.oBOX_XMIN   = xmin;
  assign bus.oBOX_XMAX   = xmax;
  assign bus.oBOX_YMIN   = ymin;
  assign bus.oBOX_YMAX   = ymax;
  assign bus.oSKIN_CNT   = skin_cnt;

endmodule

// File: tb/tb_skin_mask_extract.sv
// Directed bench for skin_mask_extract on a 4x2 pair frame.
// Frame-level model predicts mask pulses and published results.
module tb_skin_mask_extract;
  localparam int H = 4;
  localparam int V = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  skin_mask_extract_if bus();

  skin_mask_extract #(
    .H_PAIRS(H),
    .V_LINES(V),
    .CB_MIN(77),
    .CB_MAX(127),
    .CR_MIN(133),
    .CR_MAX(173)
  ) dut (
    .CMOS_PCLK(clk),
    .iRST_N(rst_n),
    .bus(bus)
  );

  typedef struct {
    int cyc; bit m; int x; int y;
  } mexp_t;
  typedef struct {
    int cyc; bit bv;
    int xmin; int xmax; int ymin; int ymax; int cnt;
  } fexp_t;
  typedef struct {
    bit m; int x; int y;
  } seen_t;

  mexp_t mq[$];
  fexp_t fq[$];
  seen_t seen[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bit in_frame = 0;
  bit pend = 0;
  int pcb = 0;
  int np = 0;
  int mxmin, mxmax, mymin, mymax, mcnt;

  always @(posedge clk) cyc++;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic flag(string name);
    total++;
    bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      while (mq.size() > 0 && mq[0].cyc < cyc) begin
        flag("mask_missing");
        void'(mq.pop_front());
      end
      if (mq.size() > 0 && mq[0].cyc == cyc) begin
        chk("mask_valid", int'(bus.oMASK_VALID), 1);
        chk("mask", int'(bus.oMASK), int'(mq[0].m));
        chk("mask_x", int'(bus.oX), mq[0].x);
        chk("mask_y", int'(bus.oY), mq[0].y);
        void'(mq.pop_front());
      end else if (bus.oMASK_VALID) begin
        flag("mask_unexpected");
      end
      if (bus.oMASK_VALID)
        seen.push_back('{bus.oMASK, int'(bus.oX), int'(bus.oY)});

      while (fq.size() > 0 && fq[0].cyc < cyc) begin
        flag("done_missing");
        void'(fq.pop_front());
      end
      if (fq.size() > 0 && fq[0].cyc == cyc) begin
        chk("frame_done", int'(bus.oFRAME_DONE), 1);
        chk("box_valid", int'(bus.oBOX_VALID), int'(fq[0].bv));
        chk("box_xmin", int'(bus.oBOX_XMIN), fq[0].xmin);
        chk("box_xmax", int'(bus.oBOX_XMAX), fq[0].xmax);
        chk("box_ymin", int'(bus.oBOX_YMIN), fq[0].ymin);
        chk("box_ymax", int'(bus.oBOX_YMAX), fq[0].ymax);
        chk("skin_cnt", int'(bus.oSKIN_CNT), fq[0].cnt);
        void'(fq.pop_front());
      end else if (bus.oFRAME_DONE) begin
        flag("done_unexpected");
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit is_skin(int b, int r);
    return b >= 77 && b <= 127 && r >= 133 && r <= 173;
  endfunction

  task automatic model_pair(int cr);
    int px, py;
    bit s;
    px = np % H;
    py = np / H;
    s = is_skin(pcb, cr);
    if (py < V) begin
      mq.push_back('{cyc + 1, s, px, py});
      if (s) begin
        if (px < mxmin) mxmin = px;
        if (px > mxmax) mxmax = px;
        if (py < mymin) mymin = py;
        if (py > mymax) mymax = py;
        if (mcnt < 131071) mcnt++;
      end
    end
    np++;
  endtask

  task automatic send_byte(int b);
    bus.iDATA = 8'(b);
    bus.iDATA_CLK = 1'b1;
    if (in_frame) begin
      if (!pend) begin
        pend = 1;
        pcb = b;
      end else begin
        pend = 0;
        model_pair(b);
      end
    end
    tick(2);
    bus.iDATA_CLK = 1'b0;
    tick(2);
  endtask

  task automatic send_pair(int b, int r);
    send_byte(b);
    send_byte(r);
  endtask

  task automatic start_frame();
    np = 0;
    pend = 0;
    mxmin = 1023;
    mxmax = 0;
    mymin = 1023;
    mymax = 0;
    mcnt = 0;
    in_frame = 1;
    seen.delete();
    bus.iDATA_VALID = 1'b1;
    tick(3);
  endtask

  task automatic end_frame();
    bus.iDATA_VALID = 1'b0;
    in_frame = 0;
    fq.push_back('{cyc + 2, mcnt != 0,
                   mxmin, mxmax, mymin, mymax, mcnt});
    tick(5);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_mv"}, int'(bus.oMASK_VALID), 0);
    chk({tag, "_m"}, int'(bus.oMASK), 0);
    chk({tag, "_x"}, int'(bus.oX), 0);
    chk({tag, "_y"}, int'(bus.oY), 0);
    chk({tag, "_fd"}, int'(bus.oFRAME_DONE), 0);
    chk({tag, "_bv"}, int'(bus.oBOX_VALID), 0);
    chk({tag, "_xmin"}, int'(bus.oBOX_XMIN), 1023);
    chk({tag, "_xmax"}, int'(bus.oBOX_XMAX), 0);
    chk({tag, "_ymin"}, int'(bus.oBOX_YMIN), 1023);
    chk({tag, "_ymax"}, int'(bus.oBOX_YMAX), 0);
    chk({tag, "_cnt"}, int'(bus.oSKIN_CNT), 0);
  endtask

  initial begin
    bus.iDATA_CLK = 1'b0;
    bus.iDATA = 8'd0;
    bus.iDATA_VALID = 1'b0;
    tick(3);
    chk_reset("rst");
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 25; i++) send_byte(i * 7);
    chk_reset("idle");

    start_frame();
    for (int i = 0; i < 8; i++) send_pair(100, 150);
    end_frame();
    chk("a_seen", seen.size(), 8);
    chk("a_last_x", seen[7].x, 3);
    chk("a_last_y", seen[7].y, 1);
    chk("a_cnt", int'(bus.oSKIN_CNT), 8);
    chk("a_bv", int'(bus.oBOX_VALID), 1);
    chk("a_xmax", int'(bus.oBOX_XMAX), 3);
    chk("a_ymax", int'(bus.oBOX_YMAX), 1);
    chk("a_xmin", int'(bus.oBOX_XMIN), 0);

    start_frame();
    send_pair(77, 133);
    send_pair(127, 173);
    send_pair(76, 150);
    send_pair(100, 174);
    end_frame();
    chk("thr_seen", seen.size(), 4);
    chk("thr0", int'(seen[0].m), 1);
    chk("thr1", int'(seen[1].m), 1);
    chk("thr2", int'(seen[2].m), 0);
    chk("thr3", int'(seen[3].m), 0);

    start_frame();
    for (int i = 0; i < 8; i++)
      send_pair(i == 6 ? 100 : 0, 150);
    end_frame();
    chk("one_xmin", int'(bus.oBOX_XMIN), 2);
    chk("one_xmax", int'(bus.oBOX_XMAX), 2);
    chk("one_ymin", int'(bus.oBOX_YMIN), 1);
    chk("one_ymax", int'(bus.oBOX_YMAX), 1);
    chk("one_cnt", int'(bus.oSKIN_CNT), 1);

    start_frame();
    for (int i = 0; i < 8; i++) send_pair(0, 150);
    end_frame();
    chk("none_bv", int'(bus.oBOX_VALID), 0);
    chk("none_xmin", int'(bus.oBOX_XMIN), 1023);
    chk("none_ymax", int'(bus.oBOX_YMAX), 0);

    start_frame();
    send_pair(100, 150);
    send_pair(100, 150);
    send_byte(100);
    end_frame();
    chk("odd_seen", seen.size(), 2);
    chk("odd_cnt", int'(bus.oSKIN_CNT), 2);

    start_frame();
    send_pair(100, 150);
    send_pair(0, 150);
    end_frame();
    chk("after_x", seen[0].x, 0);
    chk("after_y", seen[0].y, 0);
    chk("after_m", int'(seen[0].m), 1);

    start_frame();
    for (int i = 0; i < 10; i++) send_pair(110, 140);
    end_frame();
    chk("over_seen", seen.size(), 8);
    chk("over_cnt", int'(bus.oSKIN_CNT), 8);

    start_frame();
    for (int i = 0; i < 3; i++) send_pair(100, 150);
    rst_n = 1'b0;
    bus.iDATA_VALID = 1'b0;
    in_frame = 0;
    #1;
    chk_reset("midrst");
    tick(2);
    rst_n = 1'b1;
    tick(2);

    start_frame();
    send_pair(90, 160);
    send_pair(90, 160);
    end_frame();
    chk("post_x", seen[0].x, 0);
    chk("post_y", seen[0].y, 0);
    chk("post_cnt", int'(bus.oSKIN_CNT), 2);

    tick(4);
    chk("mq_empty", mq.size(), 0);
    chk("fq_empty", fq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
